// File: rtl/sdram_frame_sched.sv
// rtl/sdram_frame_sched.sv - frame-level write/read burst scheduler in front of the SDRAM arbiter
//
// Decides when to request camera write bursts and VGA read bursts, generates
// bank/row/column start addresses per burst and manages the frame buffers so
// that the reader only ever starts on a completed frame.
//
// Optional build macro: TRIPLE_BUF_EN
//   defined   - three banks; a finished frame moves the writer to the lowest
//               bank that is neither being displayed nor just completed
//   undefined - two-bank ping-pong, writer toggles 0 <-> 1
//
// Ports:
//   sysclk_100M     system clock
//   rst             synchronous active-high reset
//   init_done       SDRAM initialisation complete (only gates leaving IDLE)
//   wr_frame_start  camera vsync pulse, restarts the write frame
//   rd_frame_start  VGA vsync pulse, restarts reading on the last finished frame
//   wfifo_level     words held in the camera (write) FIFO
//   rfifo_level     words held in the VGA (read) FIFO
//   write_trig      write-burst request level, held until write_done
//   write_done      write burst finished pulse
//   read_trig       read-burst request level, held until read_done
//   read_done       read burst finished pulse
//   wr_bank/row/col start address of the current write burst
//   rd_bank/row/col start address of the current read burst
//   frame_ready     at least one complete frame is stored

module sdram_frame_sched #(
    parameter int BURST_LEN    = 256,
    parameter int FRAME_BURSTS = 1200,
    parameter int FIFO_AW      = 10,
    parameter int RD_LOW_WM    = 128
) (
    input  logic             sysclk_100M,
    input  logic             rst,
    input  logic             init_done,
    input  logic             wr_frame_start,
    input  logic             rd_frame_start,
    input  logic [FIFO_AW:0] wfifo_level,
    input  logic [FIFO_AW:0] rfifo_level,
    output logic             write_trig,
    input  logic             write_done,
    output logic             read_trig,
    input  logic             read_done,
    output logic [1:0]       wr_bank,
    output logic [12:0]      wr_row,
    output logic [8:0]       wr_col,
    output logic [1:0]       rd_bank,
    output logic [12:0]      rd_row,
    output logic [8:0]       rd_col,
    output logic             frame_ready
);

    localparam int IDX_W    = $clog2(FRAME_BURSTS) + 1;
    localparam int LVL_W    = FIFO_AW + 1;
    localparam int BL_SHIFT = $clog2(BURST_LEN);

    localparam logic [IDX_W-1:0] FRAME_N    = IDX_W'(FRAME_BURSTS);
    localparam logic [IDX_W-1:0] FRAME_LAST = IDX_W'(FRAME_BURSTS - 1);
    localparam logic [LVL_W-1:0] FIFO_DEPTH = LVL_W'(2 ** FIFO_AW);
    localparam logic [LVL_W-1:0] BURST_LVL  = LVL_W'(BURST_LEN);
    localparam logic [LVL_W-1:0] LOW_WM     = LVL_W'(RD_LOW_WM);

    typedef enum logic [1:0] {IDLE, SCHED, WR_BUSY, RD_BUSY} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   wr_idx, rd_idx;
    logic               wr_pend, rd_pend;
    logic [1:0]         last_done_bank;
    logic [1:0]         next_wr_bank;
    logic               rd_ok;
    logic [LVL_W-1:0]   rd_space;
    logic               wr_done_ev, rd_done_ev;
    logic [21:0]        wr_addr, rd_addr;

    assign wr_done_ev = (state == WR_BUSY) && write_done;
    assign rd_done_ev = (state == RD_BUSY) && read_done;

    assign wr_addr = 22'(wr_idx) << BL_SHIFT;
    assign rd_addr = 22'(rd_idx) << BL_SHIFT;
    assign wr_row  = wr_addr[21:9];
    assign wr_col  = wr_addr[8:0];
    assign rd_row  = rd_addr[21:9];
    assign rd_col  = rd_addr[8:0];

    always_comb begin
        next_wr_bank = 2'd0;
`ifdef TRIPLE_BUF_EN
        if (rd_bank != 2'd0 && wr_bank != 2'd0)
            next_wr_bank = 2'd0;
        else if (rd_bank != 2'd1 && wr_bank != 2'd1)
            next_wr_bank = 2'd1;
        else
            next_wr_bank = 2'd2;
`else
        next_wr_bank = {1'b0, ~wr_bank[0]};
`endif
    end

    // Read starvation beats writes; otherwise writes beat opportunistic reads.
    always_comb begin
        rd_ok     = frame_ready && (rd_idx < FRAME_N);
        rd_space  = FIFO_DEPTH - rfifo_level;
        state_nxt = state;
        case (state)
            IDLE:    if (init_done) state_nxt = SCHED;
            SCHED: begin
                if (rd_ok && rfifo_level <= LOW_WM)
                    state_nxt = RD_BUSY;
                else if (wfifo_level >= BURST_LVL)
                    state_nxt = WR_BUSY;
                else if (rd_ok && rd_space >= BURST_LVL)
                    state_nxt = RD_BUSY;
            end
            WR_BUSY: if (write_done) state_nxt = SCHED;
            RD_BUSY: if (read_done)  state_nxt = SCHED;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sysclk_100M) begin
        if (rst) begin
            state      <= IDLE;
            write_trig <= 1'b0;
            read_trig  <= 1'b0;
        end else begin
            state      <= state_nxt;
            write_trig <= (state_nxt == WR_BUSY);
            read_trig  <= (state_nxt == RD_BUSY);
        end
    end

    // Write side: a vsync during a burst is parked until the burst retires so
    // the address never moves under an active request.
    always_ff @(posedge sysclk_100M) begin
        if (rst) begin
            wr_idx         <= '0;
            wr_bank        <= 2'd0;
            last_done_bank <= 2'd0;
            frame_ready    <= 1'b0;
            wr_pend        <= 1'b0;
        end else if (wr_done_ev) begin
            if (wr_idx == FRAME_LAST) begin
                wr_idx         <= '0;
                last_done_bank <= wr_bank;
                wr_bank        <= next_wr_bank;
                frame_ready    <= 1'b1;
            end else begin
                wr_idx <= wr_idx + 1'b1;
            end
            // coincident vsync: the done has been counted above, now restart
            if (wr_frame_start)
                wr_idx <= '0;
        end else if (state == WR_BUSY) begin
            if (wr_frame_start)
                wr_pend <= 1'b1;
        end else if (wr_frame_start || wr_pend) begin
            wr_idx  <= '0;
            wr_pend <= 1'b0;
        end
    end

    // Read side: saturates at a full frame and waits for the next VGA vsync.
    always_ff @(posedge sysclk_100M) begin
        if (rst) begin
            rd_idx  <= '0;
            rd_bank <= 2'd0;
            rd_pend <= 1'b0;
        end else if (rd_done_ev) begin
            if (rd_idx < FRAME_N)
                rd_idx <= rd_idx + 1'b1;
            if (rd_frame_start)
                rd_pend <= 1'b1;
        end else if (state == RD_BUSY) begin
            if (rd_frame_start)
                rd_pend <= 1'b1;
        end else if (rd_frame_start || rd_pend) begin
            rd_bank <= last_done_bank;
            rd_idx  <= '0;
            rd_pend <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sdram_frame_sched.sv
// tb/tb_sdram_frame_sched.sv - self-checking bench for sdram_frame_sched

module tb_sdram_frame_sched;

    localparam int BL = 256;
    localparam int FB = 1200;

    logic        sysclk_100M = 1'b0;
    logic        rst = 1'b1, init_done = 1'b0;
    logic        wr_frame_start = 1'b0, rd_frame_start = 1'b0;
    logic        write_done = 1'b0, read_done = 1'b0;
    logic [10:0] wfifo_level = 11'd0, rfifo_level = 11'd0;
    logic        write_trig, read_trig, frame_ready;
    logic [1:0]  wr_bank, rd_bank;
    logic [12:0] wr_row, rd_row;
    logic [8:0]  wr_col, rd_col;

    int checks = 0, errors = 0;
    int m_widx = 0, m_ridx = 0, m_wr = 0, m_rd = 0, m_last = 0, m_fr = 0;

    typedef struct {
        int rlev;
        int wlev;
        int exp_wr;
        int exp_rd;
    } vec_t;
    vec_t vecs [10];

    sdram_frame_sched #(
        .BURST_LEN(BL), .FRAME_BURSTS(FB), .FIFO_AW(10), .RD_LOW_WM(128)
    ) dut (
        .sysclk_100M(sysclk_100M), .rst(rst), .init_done(init_done),
        .wr_frame_start(wr_frame_start), .rd_frame_start(rd_frame_start),
        .wfifo_level(wfifo_level), .rfifo_level(rfifo_level),
        .write_trig(write_trig), .write_done(write_done),
        .read_trig(read_trig), .read_done(read_done),
        .wr_bank(wr_bank), .wr_row(wr_row), .wr_col(wr_col),
        .rd_bank(rd_bank), .rd_row(rd_row), .rd_col(rd_col),
        .frame_ready(frame_ready)
    );

    always #5 sysclk_100M = ~sysclk_100M;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic tick;
        @(negedge sysclk_100M);
    endtask

    task automatic finish_run;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
            if (errors >= 40) finish_run();
        end
    endtask

    function automatic int next_bank(input int wr, input int rd);
`ifdef TRIPLE_BUF_EN
        for (int b = 0; b < 3; b++)
            if (b != wr && b != rd) return b;
        return 0;
`else
        return wr ^ 1;
`endif
    endfunction

    task automatic wait_trig(input bit rd_side, output bit ok);
        int n = 0;
        while ((rd_side ? read_trig : write_trig) !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        ok = ((rd_side ? read_trig : write_trig) === 1'b1);
        if (!ok) chk(rd_side ? "rd_trig_timeout" : "wr_trig_timeout", 0, 1);
    endtask

    // mode 0: plain burst, 1: vsync during busy, 2: vsync coincident with done
    task automatic wr_burst(input int mode);
        bit ok;
        wait_trig(1'b0, ok);
        if (!ok) return;
        chk("wr_bank", int'(wr_bank), m_wr);
        chk("wr_row", int'(wr_row), (m_widx * BL) >> 9);
        chk("wr_col", int'(wr_col), (m_widx * BL) & 511);
        chk("wr_excl_rd", int'(read_trig), 0);
        if (mode == 1) begin
            wr_frame_start = 1'b1;
            tick();
            wr_frame_start = 1'b0;
            chk("wr_trig_held", int'(write_trig), 1);
        end
        write_done = 1'b1;
        if (mode == 2) wr_frame_start = 1'b1;
        tick();
        write_done     = 1'b0;
        wr_frame_start = 1'b0;
        chk("wr_trig_drop", int'(write_trig), 0);
        m_widx++;
        if (m_widx == FB) begin
            m_widx = 0;
            m_last = m_wr;
            m_wr   = next_bank(m_wr, m_rd);
            m_fr   = 1;
        end
        if (mode != 0) m_widx = 0;
        chk("wr_bank_after", int'(wr_bank), m_wr);
        chk("frame_ready", int'(frame_ready), m_fr);
    endtask

    task automatic rd_burst;
        bit ok;
        wait_trig(1'b1, ok);
        if (!ok) return;
        chk("rd_bank", int'(rd_bank), m_rd);
        chk("rd_row", int'(rd_row), (m_ridx * BL) >> 9);
        chk("rd_col", int'(rd_col), (m_ridx * BL) & 511);
        chk("rd_excl_wr", int'(write_trig), 0);
        read_done = 1'b1;
        tick();
        read_done = 1'b0;
        chk("rd_trig_drop", int'(read_trig), 0);
        if (m_ridx < FB) m_ridx++;
    endtask

    initial begin
        int hi;
        bit ok;

        vecs[0] = '{100,  300, 0, 1};
        vecs[1] = '{600,  300, 1, 0};
        vecs[2] = '{600,  0,   0, 1};
        vecs[3] = '{128,  0,   0, 1};
        vecs[4] = '{800,  255, 0, 0};
        vecs[5] = '{768,  256, 1, 0};
        vecs[6] = '{768,  0,   0, 1};
        vecs[7] = '{769,  0,   0, 0};
        vecs[8] = '{1024, 0,   0, 0};
        vecs[9] = '{129,  300, 1, 0};

        // reset and init gating
        wfifo_level = 11'd300;
        rfifo_level = 11'd1024;
        repeat (3) tick();
        chk("rst_write_trig", int'(write_trig), 0);
        chk("rst_read_trig", int'(read_trig), 0);
        chk("rst_frame_ready", int'(frame_ready), 0);
        chk("rst_wr_bank", int'(wr_bank), 0);
        chk("rst_rd_bank", int'(rd_bank), 0);
        chk("rst_wr_col", int'(wr_col), 0);
        rst = 1'b0;
        hi = 0;
        repeat (50) begin
            tick();
            if (write_trig) hi++;
        end
        chk("no_trig_before_init", hi, 0);
        init_done = 1'b1;
        tick();
        chk("trig_1cyc_after_init", int'(write_trig), 0);
        tick();
        chk("trig_2cyc_after_init", int'(write_trig), 1);

        // first full frame in bank 0
        repeat (FB) wr_burst(0);
        chk("frame0_next_bank", int'(wr_bank), 1);
        chk("frame0_ready", int'(frame_ready), 1);
        chk("frame0_row", int'(wr_row), 0);

        // partial frame discarded by vsync in SCHED, then vsync during a burst
        repeat (37) wr_burst(0);
        wr_frame_start = 1'b1;
        m_widx = 0;
        tick();
        wr_frame_start = 1'b0;
        repeat (5) wr_burst(0);
        wr_burst(1);
        repeat (FB - 1) wr_burst(0);
        wr_burst(2);
        wfifo_level = 11'd0;
        tick();
`ifdef TRIPLE_BUF_EN
        chk("coincident_bank", int'(wr_bank), 2);
`else
        chk("coincident_bank", int'(wr_bank), 0);
`endif
        chk("coincident_row", int'(wr_row), 0);
        chk("coincident_col", int'(wr_col), 0);

        // priority table, all evaluated from SCHED with frame_ready set
        foreach (vecs[i]) begin
            rfifo_level = 11'(vecs[i].rlev);
            wfifo_level = 11'(vecs[i].wlev);
            tick();
            chk($sformatf("prio%0d_wr", i), int'(write_trig), vecs[i].exp_wr);
            chk($sformatf("prio%0d_rd", i), int'(read_trig), vecs[i].exp_rd);
            if (write_trig) begin
                write_done = 1'b1;
                tick();
                write_done = 1'b0;
                m_widx++;
            end else if (read_trig) begin
                read_done = 1'b1;
                tick();
                read_done = 1'b0;
                m_ridx++;
            end
            rfifo_level = 11'd1024;
            wfifo_level = 11'd0;
            tick();
        end

        // VGA vsync during a read burst is applied the cycle after read_done
        rfifo_level = 11'd100;
        wait_trig(1'b1, ok);
        chk("rdv_bank_before", int'(rd_bank), m_rd);
        chk("rdv_row_before", int'(rd_row), (m_ridx * BL) >> 9);
        rd_frame_start = 1'b1;
        tick();
        rd_frame_start = 1'b0;
        chk("rdv_trig_held", int'(read_trig), 1);
        chk("rdv_bank_deferred", int'(rd_bank), m_rd);
        read_done = 1'b1;
        tick();
        read_done = 1'b0;
        m_ridx++;
        chk("rdv_bank_at_done", int'(rd_bank), m_rd);
        chk("rdv_col_at_done", int'(rd_col), (m_ridx * BL) & 511);
        tick();
        m_rd   = m_last;
        m_ridx = 0;
        chk("rdv_bank_applied", int'(rd_bank), m_rd);
        chk("rdv_row_applied", int'(rd_row), 0);
        chk("rdv_col_applied", int'(rd_col), 0);
        chk("rdv_retrig", int'(read_trig), 1);

        // one full read frame, then no reads without a new vsync
        repeat (FB) rd_burst();
        hi = 0;
        repeat (30) begin
            tick();
            if (read_trig) hi++;
        end
        chk("no_read_after_frame", hi, 0);
        rfifo_level = 11'd1024;

        // bank selection with the reader parked on bank 1; init_done dropped
        init_done      = 1'b0;
        wfifo_level    = 11'd300;
        wr_frame_start = 1'b1;
        m_widx = 0;
        tick();
        wr_frame_start = 1'b0;
        repeat (FB) wr_burst(0);
`ifdef TRIPLE_BUF_EN
        chk("bufA_bank", int'(wr_bank), 0);
`else
        chk("bufA_bank", int'(wr_bank), 1);
`endif
        repeat (FB) wr_burst(0);
`ifdef TRIPLE_BUF_EN
        chk("bufB_bank", int'(wr_bank), 2);
`else
        chk("bufB_bank", int'(wr_bank), 0);
`endif
        wfifo_level = 11'd0;
        tick();

        // done pulses outside their busy states are ignored
        rd_frame_start = 1'b1;
        tick();
        rd_frame_start = 1'b0;
        m_rd   = m_last;
        m_ridx = 0;
        chk("vsync_rd_bank", int'(rd_bank), m_rd);
        write_done = 1'b1;
        read_done  = 1'b1;
        tick();
        write_done = 1'b0;
        read_done  = 1'b0;
        tick();
        chk("stray_wr_col", int'(wr_col), 0);
        chk("stray_wr_row", int'(wr_row), 0);
        chk("stray_rd_col", int'(rd_col), 0);
        chk("stray_rd_row", int'(rd_row), 0);

        // reset in the middle of a burst
        wfifo_level = 11'd300;
        wait_trig(1'b0, ok);
        rst = 1'b1;
        tick();
        chk("midrst_write_trig", int'(write_trig), 0);
        chk("midrst_frame_ready", int'(frame_ready), 0);
        chk("midrst_wr_bank", int'(wr_bank), 0);
        chk("midrst_rd_bank", int'(rd_bank), 0);
        rst = 1'b0;
        tick();

        finish_run();
    end

endmodule
